// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle CPU controller.
package mc_ctrl_pkg;

  localparam int OPW_C = 5;
  localparam int FW_C  = 4;
  localparam int ACW_C = 4;

  // Controller states; encodings 12..15 are unused and recover to FETCH.
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  // What the ALU decoder should produce for the current state.
  typedef enum logic [1:0] {
    ADD   = 2'd0,
    SUB   = 2'd1,
    FUNCT = 2'd2
  } aluop_t;

  // Opcodes
  localparam logic [OPW_C-1:0] OP_RTYPE = 5'h00;
  localparam logic [OPW_C-1:0] OP_LW    = 5'h01;
  localparam logic [OPW_C-1:0] OP_SW    = 5'h02;
  localparam logic [OPW_C-1:0] OP_BEQ   = 5'h03;
  localparam logic [OPW_C-1:0] OP_BNE   = 5'h04;
  localparam logic [OPW_C-1:0] OP_ADDI  = 5'h05;
  localparam logic [OPW_C-1:0] OP_J     = 5'h06;

  // R-type funct codes
  localparam logic [FW_C-1:0] FN_ADD = 4'h0;
  localparam logic [FW_C-1:0] FN_SUB = 4'h1;
  localparam logic [FW_C-1:0] FN_AND = 4'h2;
  localparam logic [FW_C-1:0] FN_OR  = 4'h3;
  localparam logic [FW_C-1:0] FN_SLT = 4'h4;

  // ALU operation codes
  localparam logic [ACW_C-1:0] ALUC_AND = 4'h0;
  localparam logic [ACW_C-1:0] ALUC_OR  = 4'h1;
  localparam logic [ACW_C-1:0] ALUC_ADD = 4'h2;
  localparam logic [ACW_C-1:0] ALUC_SUB = 4'h6;
  localparam logic [ACW_C-1:0] ALUC_SLT = 4'h7;

endpackage

// File: rtl/multicycle_aludec.sv
// ALU decoder: turns the state-selected ALU operation and the R-type funct
// into an ALU control code, flagging funct values the ALU does not implement.
module multicycle_aludec
  import mc_ctrl_pkg::*;
#(
  parameter int FW  = 4,
  parameter int ACW = 4
) (
  input  aluop_t         aluop,
  input  logic [FW-1:0]  funct,
  output logic [ACW-1:0] alucontrol,
  output logic           illegal_funct
);

  // Map operation request (and funct for R-type) onto an ALU code.
  always_comb begin
    alucontrol    = ALUC_ADD;
    illegal_funct = 1'b0;
    case (aluop)
      ADD: alucontrol = ALUC_ADD;
      SUB: alucontrol = ALUC_SUB;
      FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALUC_ADD;
          FN_SUB:  alucontrol = ALUC_SUB;
          FN_AND:  alucontrol = ALUC_AND;
          FN_OR:   alucontrol = ALUC_OR;
          FN_SLT:  alucontrol = ALUC_SLT;
          default: begin
            alucontrol    = ALUC_ADD;
            illegal_funct = 1'b1;
          end
        endcase
      end
      default: alucontrol = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU controller: sequences fetch/decode/execute/memory/writeback
// over a shared memory port and drives the datapath muxes and enables.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int OPW = 5,
  parameter int FW  = 4,
  parameter int ACW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic [FW-1:0]  funct,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           iord,
  output logic           memread,
  output logic           memwrite,
  output logic           irwrite,
  output logic           regdst,
  output logic           memtoreg,
  output logic           regwrite,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic           pcen,
  output logic [ACW-1:0] alucontrol,
  output logic           illegal_op,
  output logic [3:0]     state_o
);

  state_t         state_r;
  state_t         state_nxt_s;
  aluop_t         aluop_s;
  logic           illegal_funct_s;
  logic [ACW-1:0] aluc_s;

  // The opcode is only looked at in DECODE; the two facts later states need
  // (store vs load, BNE vs BEQ) are captured there.
  logic           is_sw_r;
  logic           is_bne_r;

  multicycle_aludec #(
    .FW  (FW),
    .ACW (ACW)
  ) u_aludec (
    .aluop         (aluop_s),
    .funct         (funct),
    .alucontrol    (aluc_s),
    .illegal_funct (illegal_funct_s)
  );

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture the instruction class while the opcode is being decoded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_sw_r  <= 1'b0;
      is_bne_r <= 1'b0;
    end else if (state_r == DECODE) begin
      is_sw_r  <= (op == OP_SW);
      is_bne_r <= (op == OP_BNE);
    end
  end

  // Next-state logic and Moore outputs, with FETCH/BRANCH enables gated.
  always_comb begin
    state_nxt_s = FETCH;
    aluop_s     = ADD;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsrc       = 2'b00;
    pcen        = 1'b0;
    illegal_op  = 1'b0;

    case (state_r)
      FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        if (mem_ready) begin
          irwrite     = 1'b1;
          pcen        = 1'b1;
          state_nxt_s = DECODE;
        end else begin
          state_nxt_s = FETCH;
        end
      end

      DECODE: begin
        // Branch target is computed here and parked in ALUOut.
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW:   state_nxt_s = MEMADR;
          OP_RTYPE:       state_nxt_s = EXEC;
          OP_BEQ, OP_BNE: state_nxt_s = BRANCH;
          OP_ADDI:        state_nxt_s = ADDIEX;
          OP_J:           state_nxt_s = JUMP;
          default: begin
            illegal_op  = 1'b1;
            state_nxt_s = FETCH;
          end
        endcase
      end

      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (is_sw_r) begin
          state_nxt_s = MEMWR;
        end else begin
          state_nxt_s = MEMRD;
        end
      end

      MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
        if (mem_ready) begin
          state_nxt_s = MEMWB;
        end else begin
          state_nxt_s = MEMRD;
        end
      end

      MEMWB: begin
        memtoreg    = 1'b1;
        regwrite    = 1'b1;
        state_nxt_s = FETCH;
      end

      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = MEMWR;
        end
      end

      EXEC: begin
        alusrca = 1'b1;
        aluop_s = FUNCT;
        if (illegal_funct_s) begin
          illegal_op  = 1'b1;
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = ALUWB;
        end
      end

      ALUWB: begin
        regdst      = 1'b1;
        regwrite    = 1'b1;
        state_nxt_s = FETCH;
      end

      BRANCH: begin
        alusrca     = 1'b1;
        aluop_s     = SUB;
        pcsrc       = 2'b01;
        pcen        = is_bne_r ? ~zero : zero;
        state_nxt_s = FETCH;
      end

      ADDIEX: begin
        alusrca     = 1'b1;
        alusrcb     = 2'b10;
        state_nxt_s = ADDIWB;
      end

      ADDIWB: begin
        regwrite    = 1'b1;
        state_nxt_s = FETCH;
      end

      JUMP: begin
        pcsrc       = 2'b10;
        pcen        = 1'b1;
        state_nxt_s = FETCH;
      end

      default: begin
        state_nxt_s = FETCH;
      end
    endcase
  end

  assign alucontrol = aluc_s;
  assign state_o    = state_r;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- FSM-based controller for the multicycle build of the 16-bit RISC CPU. Replaces the single-cycle combinational decoder.
- Sequences fetch/decode/execute/memory/writeback across multiple cycles over a shared memory port, with a memory-ready handshake.
- Generates branch/jump PC enables internally (BEQ and BNE) and flags illegal opcodes/functs.
- Sits between the instruction register fields and the multicycle datapath muxes/enables.

Parameters:
- OPW, 5, opcode field width
- FW, 4, funct field width (R-type)
- ACW, 4, alucontrol width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; forces state to FETCH
- op  input  OPW  opcode from instruction register
- funct  input  FW  funct from instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes access this cycle
- iord  output  1  0=PC addresses memory, 1=ALUOut
- memread  output  1  memory read request
- memwrite  output  1  memory write strobe
- irwrite  output  1  instruction register load
- regdst  output  1  1=rd, 0=rt
- memtoreg  output  1  1=MDR to register file
- regwrite  output  1  register file write
- alusrca  output  1  0=PC, 1=regA
- alusrcb  output  2  00=regB, 01=const 1, 10=signimm, 11=signimm (branch)
- pcsrc  output  2  00=ALU result, 01=ALUOut, 10=jump target
- pcen  output  1  PC write enable
- alucontrol  output  ACW  ALU operation
- illegal_op  output  1  one-cycle pulse on undefined op/funct
- state_o  output  4  current state (debug)

Behaviour:
- Opcodes (OPW=5): RTYPE 0x00, LW 0x01, SW 0x02, BEQ 0x03, BNE 0x04, ADDI 0x05, J 0x06; all others illegal.
- funct mapping: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT; others illegal.
- alucontrol codes: AND 0x0, OR 0x1, ADD 0x2, SUB 0x6, SLT 0x7.
- Moore outputs decoded from state; pcen and irwrite are additionally gated by mem_ready/zero as noted.
- Default for every output: 0, except alucontrol=ADD.
- After reset: state=FETCH; outputs = memread=1, alusrcb=01, alucontrol=ADD, all others 0.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, pcsrc=00. When mem_ready=1: irwrite=1, pcen=1, next state DECODE; otherwise hold in FETCH with irwrite=pcen=0.
- DECODE: alusrca=0, alusrcb=11, ADD (branch target into ALUOut). Next state by op:
  - LW/SW -> MEMADR
  - RTYPE -> EXEC
  - BEQ/BNE -> BRANCH
  - ADDI -> ADDIEX
  - J -> JUMP
  - illegal -> FETCH with illegal_op=1 for that cycle
- MEMADR: alusrca=1, alusrcb=10, ADD. Next state LW -> MEMRD, SW -> MEMWR.
- MEMRD: iord=1, memread=1; hold until mem_ready, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWR: iord=1, memwrite=1 held until mem_ready, then FETCH.
- EXEC: alusrca=1, alusrcb=00, alucontrol from funct. Legal funct -> ALUWB; illegal funct -> FETCH with illegal_op=1 and no write.
- ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, SUB, pcsrc=01. pcen = (zero & BEQ) | (~zero & BNE). -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, ADD -> ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
- JUMP: pcsrc=10, pcen=1 -> FETCH.
- Latencies, cycles per instruction with mem_ready always high:
  - LW 5, SW 4, R-type 4, ADDI 4, BEQ/BNE 3, J 3
  - each wait cycle on mem_ready adds 1
- Boundary conditions:
  - reset asserted in any state, including mid-MEMWR: state returns to FETCH immediately (asynchronously) and memwrite drops in the same cycle.
  - mem_ready outside FETCH/MEMRD/MEMWR is ignored.
  - op/funct are sampled only in DECODE/EXEC; the IR holds them stable.
  - Unused state encodings -> FETCH.

Decomposition:
- Package mc_ctrl_pkg:
  - state_t enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP; 4-bit)
  - opcode localparams
  - funct localparams
  - alucontrol localparams
  - aluop_t (ADD, SUB, FUNCT)
- Sub-module multicycle_aludec: aluop_t + funct -> alucontrol, plus illegal_funct flag.

Test Plan:
- Reset mid-MEMWR (reset=1 while memwrite=1) -> memwrite=0 same cycle; state_o=FETCH; memread=1, alusrcb=01.
- LW (op=0x01), mem_ready tied 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 with memtoreg=1 only in cycle 5.
- FETCH with mem_ready low for 3 cycles -> irwrite=pcen=0 for 3 cycles, both 1 on cycle 4, then DECODE.
- BEQ and BNE (op=0x03/0x04), each with zero=1 and zero=0 -> pcen=1 only for BEQ/zero=1 and BNE/zero=0; pcsrc=01 in BRANCH.
- R-type funct=1 -> alucontrol=0x6 in EXEC, regwrite=1 with regdst=1 in ALUWB. R-type funct=0xF -> illegal_op pulse, no regwrite, back to FETCH.
- op=0x1F -> illegal_op=1 in DECODE, next state FETCH; J (op=0x06) -> pcen=1, pcsrc=10, 3-cycle instruction.
